// File: rtl/ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle control unit: opcode/function
// encodings, controller states and the datapath strobe bundle.
package ctrl_fsm_pkg;

  localparam logic [2:0] opADD   = 3'd0;
  localparam logic [2:0] opSUB   = 3'd1;
  localparam logic [2:0] opSEI   = 3'd2;
  localparam logic [2:0] opCEQ   = 3'd3;
  localparam logic [2:0] opCLT   = 3'd4;
  localparam logic [2:0] opSW    = 3'd5;
  localparam logic [2:0] opLW    = 3'd6;
  localparam logic [2:0] opOTHER = 3'd7;

  localparam logic [2:0] fnB0    = 3'd0;
  localparam logic [2:0] fnB1    = 3'd1;
  localparam logic [2:0] fnHALT  = 3'd7;

  typedef enum logic [1:0] {IDLE, RUN, MEMWAIT, DONE} ctrl_state_t;

  // is_load / is_halt are decode hints for the sequencer, not datapath strobes
  typedef struct packed {
    logic branch_en;
    logic pc_en;
    logic flag_write;
    logic overflow_write;
    logic mem_read;
    logic mem_write;
    logic reg_wr_en;
    logic reg_wr_imm_en;
    logic is_load;
    logic is_halt;
  } ctrl_sig_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational instruction decoder: opcode/function plus the registered
// flag map onto the single-cycle strobe bundle.
module ctrl_decode
  import ctrl_fsm_pkg::*;
#(
  parameter int OPW = 3,
  parameter int FNW = 3
) (
  input  logic [OPW-1:0] opcode,
  input  logic [FNW-1:0] funct,
  input  logic           flag_q,
  output ctrl_sig_t      sig
);

  // Loads are decoded as single-cycle; the sequencer stretches them when needed
  always_comb begin
    sig       = '0;
    sig.pc_en = 1'b1;
    case (opcode)
      OPW'(opADD), OPW'(opSUB): begin
        sig.reg_wr_en      = 1'b1;
        sig.overflow_write = 1'b1;
      end
      OPW'(opSEI): begin
        sig.reg_wr_en     = 1'b1;
        sig.reg_wr_imm_en = 1'b1;
      end
      OPW'(opCEQ), OPW'(opCLT): sig.flag_write = 1'b1;
      OPW'(opSW):  sig.mem_write = 1'b1;
      OPW'(opLW): begin
        sig.mem_read  = 1'b1;
        sig.reg_wr_en = 1'b1;
        sig.is_load   = 1'b1;
      end
      OPW'(opOTHER): begin
        case (funct)
          FNW'(fnB0): sig.branch_en = ~flag_q;
          FNW'(fnB1): sig.branch_en = flag_q;
          FNW'(fnHALT): begin
            sig.pc_en   = 1'b0;
            sig.is_halt = 1'b1;
          end
          default: begin
            sig.reg_wr_en      = 1'b1;
            sig.overflow_write = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle controller: wraps the decoder with IDLE/RUN/MEMWAIT/DONE
// sequencing, the compare-flag register and the load-latency stall counter.
module ctrl_fsm
  import ctrl_fsm_pkg::*;
#(
  parameter int IW      = 9,
  parameter int OPW     = 3,
  parameter int FNW     = 3,
  parameter int MEM_LAT = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [IW-1:0] Instruction,
  input  logic          FLAG_IN,
  output logic          branch_en,
  output logic          pc_en,
  output logic          flag_write,
  output logic          overflow_write,
  output logic          MEM_READ,
  output logic          MEM_WRITE,
  output logic          reg_wr_en,
  output logic          reg_wr_imm_en,
  output logic          flag_q,
  output logic          Done
);

  ctrl_state_t state, next_state;
  logic [2:0]  wait_cnt, cnt_next;
  ctrl_sig_t   dec_sig, sig_out;
  logic        unused_bits;

  assign unused_bits = ^Instruction[IW-OPW-1:FNW];

  ctrl_decode #(.OPW(OPW), .FNW(FNW)) u_decode (
    .opcode (Instruction[IW-1 -: OPW]),
    .funct  (Instruction[FNW-1:0]),
    .flag_q (flag_q),
    .sig    (dec_sig)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
      flag_q   <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= cnt_next;
      if (sig_out.flag_write)
        flag_q <= FLAG_IN;
    end
  end

  // Idle, halt and stall override the decoded bundle; MEMWAIT ignores Instruction
  always_comb begin
    next_state = state;
    cnt_next   = wait_cnt;
    sig_out    = '0;
    case (state)
      IDLE: if (Start) next_state = RUN;
      RUN: begin
        sig_out = dec_sig;
        if (dec_sig.is_halt) begin
          sig_out    = '0;
          next_state = DONE;
        end else if (dec_sig.is_load && (MEM_LAT > 1)) begin
          sig_out.pc_en     = 1'b0;
          sig_out.reg_wr_en = 1'b0;
          cnt_next          = 3'(MEM_LAT - 1);
          next_state        = MEMWAIT;
        end
      end
      MEMWAIT: begin
        sig_out.mem_read = 1'b1;
        cnt_next         = wait_cnt - 3'd1;
        if (wait_cnt == 3'd1) begin
          sig_out.reg_wr_en = 1'b1;
          sig_out.pc_en     = 1'b1;
          next_state        = RUN;
        end
      end
      DONE: if (Start) next_state = RUN;
      default: next_state = IDLE;
    endcase
  end

  assign branch_en      = sig_out.branch_en;
  assign pc_en          = sig_out.pc_en;
  assign flag_write     = sig_out.flag_write;
  assign overflow_write = sig_out.overflow_write;
  assign MEM_READ       = sig_out.mem_read;
  assign MEM_WRITE      = sig_out.mem_write;
  assign reg_wr_en      = sig_out.reg_wr_en;
  assign reg_wr_imm_en  = sig_out.reg_wr_imm_en;
  assign Done           = (state == DONE);

endmodule

// File: doc/ctrl_fsm.md
Name: ctrl_fsm

Overview:
Parametrised, multi-cycle successor to the combinational control decoder. It decodes the current instruction into datapath strobes and keeps the compare flag in an internal register. It stalls the fetch unit for configurable-latency loads and supports a halt/start handshake with the test harness. It sits between instruction ROM and program counter, register file, ALU and data memory.

Parameters:
IW, 9, instruction width in bits
OPW, 3, opcode field width; the opcode is Instruction[IW-1 -: OPW]
FNW, 3, function field width for opOTHER; the function is Instruction[FNW-1:0]
MEM_LAT, 1, data-memory read latency in cycles (1..7); 0 is illegal

Ports:
Clk  in  1  system clock; all state changes on the rising edge
Reset  in  1  synchronous, active-high reset
Start  in  1  one-cycle pulse that begins execution from IDLE or DONE
Instruction  in  IW  current machine code from instruction ROM
FLAG_IN  in  1  compare result from the ALU, valid during CEQ/CLT
branch_en  out  1  PC takes the branch target this cycle
pc_en  out  1  PC advances or branches this cycle; 0 means stall
flag_write  out  1  flag register captures FLAG_IN at this edge
overflow_write  out  1  overflow register captures the ALU carry
MEM_READ  out  1  data-memory read request
MEM_WRITE  out  1  data-memory write strobe
reg_wr_en  out  1  register-file write enable
reg_wr_imm_en  out  1  write-data mux selects the immediate
flag_q  out  1  registered compare flag
Done  out  1  processor halted

Behaviour:
- States: IDLE, RUN, MEMWAIT, DONE.
- Reset: state=IDLE, flag_q=0, wait counter=0. All outputs are 0 in the cycle after Reset, and Reset overrides every other input, including mid-MEMWAIT.
- IDLE: all strobes=0, pc_en=0, Done=0. When Start=1, go to RUN.
- RUN: decode one instruction per cycle, with pc_en=1 by default.
  - opADD, opSUB: reg_wr_en=1, overflow_write=1.
  - opSEI: reg_wr_en=1, reg_wr_imm_en=1.
  - opCEQ, opCLT: flag_write=1, reg_wr_en=0. flag_q<=FLAG_IN at the edge.
  - opSW: MEM_WRITE=1, reg_wr_en=0.
  - opLW: MEM_READ=1. Then:
    - if MEM_LAT=1: reg_wr_en=1 in the same cycle and stay in RUN;
    - else: pc_en=0, reg_wr_en=0, load the counter with MEM_LAT-1 and go to MEMWAIT.
  - opOTHER with fnB0: branch_en = ~flag_q. With fnB1: branch_en = flag_q. For both: reg_wr_en=0, overflow_write=0.
  - opOTHER with fnHALT: all strobes=0, pc_en=0, go to DONE.
  - Any other opOTHER function: reg_wr_en=1, overflow_write=1 (shift/logic ops).
  - Branches always use the registered flag_q, never FLAG_IN. A compare followed immediately by a branch sees the new flag.
- MEMWAIT:
  - MEM_READ=1 and pc_en=0 throughout; the counter decrements each cycle.
  - When the counter is 1: reg_wr_en=1, pc_en=1, return to RUN.
  - Instruction is held stable by the stalled PC and is not re-decoded.
- DONE: Done=1 and all strobes=0. When Start=1, go to RUN; the PC is reset externally.
- Start is ignored in RUN and MEMWAIT.
- Unknown opcodes decode to no-op with pc_en=1. This must never produce X on any output.
- All strobes are combinational from state and Instruction. flag_q and state are registered.

Decomposition:
- The definitions package gains fnHALT and a ctrl_state_t enum {IDLE, RUN, MEMWAIT, DONE}. The op*/fn* constants stay there.
- Sub-module ctrl_decode: a pure combinational map from opcode/function and flag_q to the strobe bundle (a packed struct ctrl_sig_t in the package). ctrl_fsm overrides the bundle for stall, halt and idle.

Test Plan:
1. Reset held 3 cycles while Instruction=opADD -> every output 0 and state IDLE. Start pulse -> next cycle reg_wr_en=1, overflow_write=1, pc_en=1.
2. CEQ with FLAG_IN=1, then fnB1 -> flag_q=1, branch_en=1. CEQ with FLAG_IN=0, then fnB1 -> branch_en=0. The same sequences with fnB0 give the opposite result.
3. MEM_LAT=3, opLW -> MEM_READ=1 for 3 cycles; pc_en=0,0,1; reg_wr_en=0,0,1. Then back in RUN.
4. MEM_LAT=1, opLW -> MEM_READ=1, reg_wr_en=1, pc_en=1 in a single cycle, no MEMWAIT.
5. Reset asserted during the second MEMWAIT cycle -> next cycle IDLE, all outputs 0, flag_q=0.
6. fnHALT -> pc_en=0 and Done=1 from the next cycle. Done holds for 10 cycles. Start -> Done=0 and RUN resumes. Branch and SW instructions keep reg_wr_en=0 throughout.
